// File: rtl/pcie_egress_scheduler_pkg.sv
// rtl/pcie_egress_scheduler_pkg.sv - shared encodings and command codes for the egress scheduler
package pcie_egress_scheduler_pkg;

  // TLP fmt/type bytes for 64-bit-address memory write and memory read
  localparam logic [7:0] PCIE_MWR_64B = 8'h60;
  localparam logic [7:0] PCIE_MRD_64B = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef enum logic {
    CH_WR = 1'b0,
    CH_RD = 1'b1
  } chan_e;

endpackage

// File: rtl/pcie_egress_scheduler_if.sv
// rtl/pcie_egress_scheduler_if.sv - scheduler to egress engine handshake and header bus
interface pcie_egress_scheduler_if;
  logic        enable;
  logic        finished;
  logic [7:0]  command;
  logic [13:0] flags;
  logic [63:0] address;
  logic [15:0] requester_id;
  logic [7:0]  tag;
  logic [9:0]  dword_cnt;

  modport master (
    output enable, command, flags, address, requester_id, tag, dword_cnt,
    input  finished
  );

  modport slave (
    input  enable, command, flags, address, requester_id, tag, dword_cnt,
    output finished
  );
endinterface

// File: rtl/pcie_egress_scheduler_tag_pool.sv
// rtl/pcie_egress_scheduler_tag_pool.sv - read-tag allocation bitmap with lowest-free pick and release checking
module pcie_tag_pool #(
  parameter int TAG_COUNT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_stb_i,
  output logic [7:0] alloc_tag_o,
  output logic       free_avail_o,
  input  logic       release_stb_i,
  input  logic [7:0] release_tag_i,
  output logic [8:0] count_o,
  output logic       error_o
);
  localparam int TW = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;

  logic [TAG_COUNT-1:0] alloc_q, alloc_d;
  logic [8:0]           count_q, count_d;
  logic                 error_q;
  logic [TW-1:0]        free_idx;
  logic                 rel_in_range;
  logic                 rel_valid;
  logic                 do_alloc;

  // Priority encoder: scanning from the top leaves the lowest free index
  always_comb begin
    free_idx = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (!alloc_q[i]) free_idx = TW'(i);
    end
  end

  assign free_avail_o = ~&alloc_q;
  assign alloc_tag_o  = 8'(free_idx);
  assign rel_in_range = {1'b0, release_tag_i} < 9'(TAG_COUNT);
  assign rel_valid    = release_stb_i && rel_in_range && alloc_q[release_tag_i[TW-1:0]];
  assign do_alloc     = alloc_stb_i && free_avail_o;

  // Next pool state: allocation and release never target the same tag
  always_comb begin
    alloc_d = alloc_q;
    if (do_alloc) alloc_d[free_idx] = 1'b1;
    if (rel_valid) alloc_d[release_tag_i[TW-1:0]] = 1'b0;
    count_d = count_q + 9'(do_alloc) - 9'(rel_valid);
  end

  // Pool registers and one-cycle error flag for bad releases
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      count_q <= count_d;
      error_q <= release_stb_i && !rel_valid;
    end
  end

  assign count_o = count_q;
  assign error_o = error_q;
endmodule

// File: rtl/pcie_egress_scheduler.sv
// rtl/pcie_egress_scheduler.sv - round-robin sharing of the egress engine between DMA write and read channels
module pcie_egress_scheduler
  import pcie_egress_scheduler_pkg::*;
#(
  parameter int         TAG_COUNT = 32,
  parameter logic [7:0] CMD_MWR   = PCIE_MWR_64B,
  parameter logic [7:0] CMD_MRD   = PCIE_MRD_64B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [13:0] i_flags,
  input  logic [15:0] i_pcie_id,
  input  logic        i_wr_req,
  input  logic [63:0] i_wr_address,
  output logic        o_wr_done,
  input  logic        i_rd_req,
  input  logic [63:0] i_rd_address,
  input  logic [9:0]  i_rd_dword_cnt,
  output logic        o_rd_done,
  output logic [7:0]  o_rd_tag,
  input  logic        i_tag_release_stb,
  input  logic [7:0]  i_tag_release,
  output logic [8:0]  o_tags_outstanding,
  output logic        o_tag_error,
  output logic        o_busy,
  pcie_egress_scheduler_if.master egress
);
  state_e      state_q;
  chan_e       last_q;
  logic        enable_q, wr_done_q, rd_done_q;
  logic [7:0]  command_q, tag_q, rd_tag_q;
  logic [13:0] flags_q;
  logic [63:0] address_q;
  logic [15:0] req_id_q;
  logic [9:0]  cnt_q;

  logic       free_avail;
  logic [7:0] alloc_tag;
  logic       wr_elig, rd_elig, any_elig, grant_rd, alloc_stb;

  assign wr_elig   = i_enable && i_wr_req;
  assign rd_elig   = i_enable && i_rd_req && free_avail;
  assign any_elig  = wr_elig || rd_elig;
  // On a tie the channel not granted last wins
  assign grant_rd  = rd_elig && (!wr_elig || (last_q == CH_WR));
  assign alloc_stb = (state_q == ST_IDLE) && grant_rd;

  pcie_tag_pool #(.TAG_COUNT(TAG_COUNT)) u_tag_pool (
    .clk           (clk),
    .rst           (rst),
    .alloc_stb_i   (alloc_stb),
    .alloc_tag_o   (alloc_tag),
    .free_avail_o  (free_avail),
    .release_stb_i (i_tag_release_stb),
    .release_tag_i (i_tag_release),
    .count_o       (o_tags_outstanding),
    .error_o       (o_tag_error)
  );

  // Grant/issue/release sequencer; all engine-facing fields are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= CH_RD;
      enable_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      command_q <= '0;
      tag_q     <= '0;
      rd_tag_q  <= '0;
      flags_q   <= '0;
      address_q <= '0;
      req_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            enable_q <= 1'b1;
            flags_q  <= i_flags;
            req_id_q <= i_pcie_id;
            if (grant_rd) begin
              last_q    <= CH_RD;
              command_q <= CMD_MRD;
              address_q <= i_rd_address;
              tag_q     <= alloc_tag;
              cnt_q     <= i_rd_dword_cnt;
            end else begin
              last_q    <= CH_WR;
              command_q <= CMD_MWR;
              address_q <= i_wr_address;
              tag_q     <= '0;
              cnt_q     <= '0;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (egress.finished) begin
            enable_q <= 1'b0;
            if (last_q == CH_RD) begin
              rd_done_q <= 1'b1;
              rd_tag_q  <= tag_q;
            end else begin
              wr_done_q <= 1'b1;
            end
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!egress.finished) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign egress.enable       = enable_q;
  assign egress.command      = command_q;
  assign egress.flags        = flags_q;
  assign egress.address      = address_q;
  assign egress.requester_id = req_id_q;
  assign egress.tag          = tag_q;
  assign egress.dword_cnt    = cnt_q;
  assign o_wr_done           = wr_done_q;
  assign o_rd_done           = rd_done_q;
  assign o_rd_tag            = rd_tag_q;
  assign o_busy              = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pcie_egress_scheduler.sv
// tb/tb_pcie_egress_scheduler.sv - randomized self-checking bench against a packet-level reference model
module tb_pcie_egress_scheduler;
  import pcie_egress_scheduler_pkg::*;

  localparam int TAGS = 32;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic [13:0] i_flags;
  logic [15:0] i_pcie_id;
  logic        i_wr_req;
  logic [63:0] i_wr_address;
  logic        o_wr_done;
  logic        i_rd_req;
  logic [63:0] i_rd_address;
  logic [9:0]  i_rd_dword_cnt;
  logic        o_rd_done;
  logic [7:0]  o_rd_tag;
  logic        i_tag_release_stb;
  logic [7:0]  i_tag_release;
  logic [8:0]  o_tags_outstanding;
  logic        o_tag_error;
  logic        o_busy;

  pcie_egress_scheduler_if eg ();

  pcie_egress_scheduler #(.TAG_COUNT(TAGS)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_enable           (i_enable),
    .i_flags            (i_flags),
    .i_pcie_id          (i_pcie_id),
    .i_wr_req           (i_wr_req),
    .i_wr_address       (i_wr_address),
    .o_wr_done          (o_wr_done),
    .i_rd_req           (i_rd_req),
    .i_rd_address       (i_rd_address),
    .i_rd_dword_cnt     (i_rd_dword_cnt),
    .o_rd_done          (o_rd_done),
    .o_rd_tag           (o_rd_tag),
    .i_tag_release_stb  (i_tag_release_stb),
    .i_tag_release      (i_tag_release),
    .o_tags_outstanding (o_tags_outstanding),
    .o_tag_error        (o_tag_error),
    .o_busy             (o_busy),
    .egress             (eg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which tags are out, how many, and who won last
  bit m_alloc[TAGS];
  int m_count;
  bit m_last_rd;
  bit rand_rel;

  logic [7:0] got_cmd;
  logic [7:0] got_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < TAGS; i++) if (!m_alloc[i]) return i;
    return -1;
  endfunction

  // One clock: apply any pending release (optionally random) and check the pool
  task automatic tick(input bit do_alloc);
    int exp_tag;
    int rt;
    bit stb;
    bit rel_ok;
    if (rand_rel && !i_tag_release_stb && $urandom_range(0, 3) == 0) begin
      i_tag_release_stb = 1'b1;
      i_tag_release = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, TAGS - 1));
    end
    stb = i_tag_release_stb;
    rt = int'(i_tag_release);
    rel_ok = 1'b0;
    if (stb && rt < TAGS) rel_ok = m_alloc[rt];
    exp_tag = lowest_free();
    @(posedge clk);
    #1;
    if (do_alloc) begin
      m_alloc[exp_tag] = 1'b1;
      m_count++;
    end
    if (rel_ok) begin
      m_alloc[rt] = 1'b0;
      m_count--;
    end
    i_tag_release_stb = 1'b0;
    check("tag_error", 64'(o_tag_error), 64'(stb && !rel_ok));
    check("tags_outstanding", 64'(o_tags_outstanding), 64'(m_count));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_enable = 1'b0; i_flags = '0; i_pcie_id = '0;
    i_wr_req = 1'b0; i_wr_address = '0;
    i_rd_req = 1'b0; i_rd_address = '0; i_rd_dword_cnt = '0;
    i_tag_release_stb = 1'b0; i_tag_release = '0;
    eg.finished = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < TAGS; i++) m_alloc[i] = 1'b0;
    m_count = 0;
    m_last_rd = 1'b1;
    check("rst_enable", 64'(eg.enable), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_count", 64'(o_tags_outstanding), 64'(0));
    check("rst_outputs", 64'({o_wr_done, o_rd_done, o_rd_tag, o_tag_error, eg.command, eg.tag}), 64'(0));
    check("rst_address", eg.address, 64'(0));
    rst = 1'b0;
  endtask

  // Present requests, play the engine for one packet, and compare against the model
  task automatic grant(input bit wr, input bit rd, input bit en, input logic [63:0] wa,
                       input logic [63:0] ra, input logic [9:0] cnt, input int hold, input int linger);
    bit wr_el, rd_el, win_rd;
    int exp_tag;
    logic [13:0] fl;
    logic [15:0] id;
    fl = 14'($urandom);
    id = 16'($urandom);
    i_flags = fl; i_pcie_id = id;
    i_wr_req = wr; i_rd_req = rd; i_enable = en;
    i_wr_address = wa; i_rd_address = ra; i_rd_dword_cnt = cnt;
    wr_el = wr && en;
    rd_el = rd && en && (m_count < TAGS);
    got_cmd = '0;
    got_tag = '0;
    if (!wr_el && !rd_el) begin
      tick(1'b0);
      check("no_grant_enable", 64'(eg.enable), 64'(0));
      check("no_grant_busy", 64'(o_busy), 64'(0));
      i_wr_req = 1'b0; i_rd_req = 1'b0;
      return;
    end
    win_rd = rd_el && (!wr_el || !m_last_rd);
    exp_tag = win_rd ? lowest_free() : 0;
    tick(win_rd);
    m_last_rd = win_rd;
    got_cmd = eg.command;
    got_tag = eg.tag;
    check("grant_enable", 64'(eg.enable), 64'(1));
    check("grant_busy", 64'(o_busy), 64'(1));
    check("grant_command", 64'(eg.command), 64'(win_rd ? PCIE_MRD_64B : PCIE_MWR_64B));
    check("grant_address", eg.address, win_rd ? ra : wa);
    check("grant_tag", 64'(eg.tag), 64'(exp_tag));
    check("grant_dword_cnt", 64'(eg.dword_cnt), 64'(win_rd ? cnt : 10'd0));
    check("grant_flags_id", 64'({eg.flags, eg.requester_id}), 64'({fl, id}));
    for (int h = 0; h < hold; h++) begin
      i_enable = 1'($urandom);
      tick(1'b0);
      check("hold_enable", 64'(eg.enable), 64'(1));
      check("hold_address", eg.address, win_rd ? ra : wa);
      check("hold_no_done", 64'({o_wr_done, o_rd_done}), 64'(0));
    end
    eg.finished = 1'b1;
    tick(1'b0);
    check("done_enable", 64'(eg.enable), 64'(0));
    check("wr_done", 64'(o_wr_done), 64'(!win_rd));
    check("rd_done", 64'(o_rd_done), 64'(win_rd));
    if (win_rd) check("rd_tag", 64'(o_rd_tag), 64'(exp_tag));
    i_wr_req = 1'b0; i_rd_req = 1'b0;
    for (int l = 0; l < linger; l++) begin
      tick(1'b0);
      check("release_pulse_gone", 64'({o_wr_done, o_rd_done}), 64'(0));
      check("release_busy", 64'(o_busy), 64'(1));
    end
    eg.finished = 1'b0;
    tick(1'b0);
    check("back_to_idle", 64'(o_busy), 64'(0));
  endtask

  initial begin
    rand_rel = 1'b0;
    do_reset();

    // Single write to a 64-bit address
    grant(1'b1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 64'h0, 10'd0, 1, 0);
    check("first_write_cmd", 64'(got_cmd), 64'(PCIE_MWR_64B));

    // Two reads take tags 0 then 1
    grant(1'b0, 1'b1, 1'b1, 64'h0, 64'h0000_0000_dead_b000, 10'd16, 0, 1);
    check("read1_tag", 64'(got_tag), 64'(0));
    grant(1'b0, 1'b1, 1'b1, 64'h0, 64'h0000_0000_dead_c000, 10'd16, 2, 0);
    check("read2_tag", 64'(got_tag), 64'(1));
    check("two_outstanding", 64'(o_tags_outstanding), 64'(2));

    // Both channels requesting: W,R,W,R from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      grant(1'b1, 1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 10'($urandom), 0, 0);
      check("alternate_order", 64'(got_cmd), 64'((i % 2) ? PCIE_MRD_64B : PCIE_MWR_64B));
    end

    // Fill the pool, then writes keep flowing
    while (m_count < TAGS)
      grant(1'b0, 1'b1, 1'b1, 64'h0, {$urandom, $urandom}, 10'($urandom), 0, 0);
    check("pool_full", 64'(o_tags_outstanding), 64'(TAGS));
    grant(1'b0, 1'b1, 1'b1, 64'h0, 64'h1000, 10'd4, 0, 0);
    check("full_read_blocked", 64'(got_cmd), 64'(0));
    for (int i = 0; i < 2; i++) begin
      grant(1'b1, 1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 10'd8, 0, 0);
      check("full_write_only", 64'(got_cmd), 64'(PCIE_MWR_64B));
    end

    // Release tag 5, next read reuses it
    i_tag_release_stb = 1'b1; i_tag_release = 8'd5;
    tick(1'b0);
    grant(1'b0, 1'b1, 1'b1, 64'h0, 64'h2000, 10'd1, 0, 0);
    check("reuse_tag5", 64'(got_tag), 64'(5));

    // Tag 7: valid release, then a second release of it is an error
    i_tag_release_stb = 1'b1; i_tag_release = 8'd7;
    tick(1'b0);
    i_tag_release_stb = 1'b1; i_tag_release = 8'd7;
    tick(1'b0);
    check("double_release_err", 64'(o_tag_error), 64'(1));
    check("double_release_count", 64'(o_tags_outstanding), 64'(TAGS - 1));
    i_tag_release_stb = 1'b1; i_tag_release = 8'd40;
    tick(1'b0);
    check("range_release_err", 64'(o_tag_error), 64'(1));

    // Release tag 3 in the same cycle a read allocates tag 7
    i_tag_release_stb = 1'b1; i_tag_release = 8'd3;
    grant(1'b0, 1'b1, 1'b1, 64'h0, 64'h3000, 10'd2, 0, 0);
    check("same_cycle_tag", 64'(got_tag), 64'(7));
    check("same_cycle_count", 64'(o_tags_outstanding), 64'(TAGS - 1));

    // Reset while a packet is in ISSUE
    i_enable = 1'b1; i_wr_req = 1'b1; i_wr_address = 64'h4000;
    tick(1'b0);
    m_last_rd = 1'b0;
    check("pre_rst_enable", 64'(eg.enable), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_enable", 64'(eg.enable), 64'(0));
    check("mid_rst_busy", 64'(o_busy), 64'(0));
    check("mid_rst_count", 64'(o_tags_outstanding), 64'(0));
    do_reset();

    // Randomized traffic with random releases
    rand_rel = 1'b1;
    for (int n = 0; n < 200; n++) begin
      grant(1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
            {$urandom, $urandom}, {$urandom, $urandom}, 10'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
